// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults and FSM encoding for the multi-port register file
// Contents: default widths/depth and the clear-sequencer state type.
package regfile_mp_pkg;

  localparam int REG_ADDRW = 5;
  localparam int CPU_WIDTH = 64;
  localparam int REG_COUNT = 2 ** REG_ADDRW;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/control bundle of the multi-port register file
// Signals: i_clr_req, i_wen[NWR], i_waddr/i_wdata (packed per write port),
//          i_raddr (packed per read port), o_rdata, o_ready, o_wconflict, s_a0zero.
// Modports: master drives the requests, slave is the register file.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = CPU_WIDTH,
  parameter int ADDR_W = REG_ADDRW,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) ();

  logic                    i_clr_req;
  logic [NWR-1:0]          i_wen;
  logic [NWR*ADDR_W-1:0]   i_waddr;
  logic [NWR*DATA_W-1:0]   i_wdata;
  logic [NRD*ADDR_W-1:0]   i_raddr;
  logic [NRD*DATA_W-1:0]   o_rdata;
  logic                    o_ready;
  logic                    o_wconflict;
  logic                    s_a0zero;

  modport master (
    output i_clr_req, i_wen, i_waddr, i_wdata, i_raddr,
    input  o_rdata, o_ready, o_wconflict, s_a0zero
  );

  modport slave (
    input  i_clr_req, i_wen, i_waddr, i_wdata, i_raddr,
    output o_rdata, o_ready, o_wconflict, s_a0zero
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - clear sequencer: walks entries 1..DEPTH-1 writing zero, then declares ready
// Ports: i_clk, i_rst_n (async, active-low), i_clr_req (honoured only when ready),
//        o_clr_we / o_clr_addr (zeroing write strobe and index), o_ready.
module regfile_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = REG_ADDRW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr_req,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  // Entry 0 is hardwired, so the walk starts at 1 and ends at the all-ones index.
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      RF_ST_CLEAR: begin
        cnt_d = cnt_q + FIRST_IDX;
        if (cnt_q == LAST_IDX) begin
          state_d = RF_ST_READY;
          ready_d = 1'b1;
        end
      end
      RF_ST_READY: begin
        if (i_clr_req) begin
          state_d = RF_ST_CLEAR;
          cnt_d   = FIRST_IDX;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = RF_ST_CLEAR;
        cnt_d   = FIRST_IDX;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RF_ST_CLEAR;
      cnt_q   <= FIRST_IDX;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign o_clr_we   = (state_q == RF_ST_CLEAR);
  assign o_clr_addr = cnt_q;
  assign o_ready    = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD-read / NWR-write register file with hardwired-zero entry 0 and hardware clear
// Ports: i_clk, i_rst_n (async, active-low), rf_if (regfile_mp_if.slave: write ports,
//        read ports, clear request, o_ready, o_wconflict, s_a0zero).
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = CPU_WIDTH,
  parameter int ADDR_W = REG_ADDRW,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int A0_IDX = 10
) (
  input logic          i_clk,
  input logic          i_rst_n,
  regfile_mp_if.slave  rf_if
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              wconflict_q, wconflict_d;

  logic [ADDR_W-1:0] waddr [NWR];
  logic [DATA_W-1:0] wdata [NWR];
  logic [ADDR_W-1:0] raddr [NRD];
  logic [DATA_W-1:0] rdata [NRD];

  for (genvar k = 0; k < NWR; k++) begin : g_wunpack
    assign waddr[k] = rf_if.i_waddr[k*ADDR_W +: ADDR_W];
    assign wdata[k] = rf_if.i_wdata[k*DATA_W +: DATA_W];
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rport
    assign raddr[r] = rf_if.i_raddr[r*ADDR_W +: ADDR_W];
    assign rf_if.o_rdata[r*DATA_W +: DATA_W] = rdata[r];
  end

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr_req  (rf_if.i_clr_req),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr),
    .o_ready    (ready)
  );

  // Ports are applied in ascending order so the highest-indexed port wins a collision.
  // Sequencer writes only happen while not ready, so they never overlap user writes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) rf_d[i] = rf_q[i];
    if (clr_we) rf_d[clr_addr] = '0;
    if (ready) begin
      for (int k = 0; k < NWR; k++) begin
        if (rf_if.i_wen[k] && (waddr[k] != '0)) rf_d[waddr[k]] = wdata[k];
      end
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge i_clk) begin
    rf_q <= rf_d;
  end

  always_comb begin
    wconflict_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (rf_if.i_wen[i] && rf_if.i_wen[j] && (waddr[i] == waddr[j]) && (waddr[i] != '0))
          wconflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wconflict_q <= 1'b0;
    else          wconflict_q <= wconflict_d;
  end

  // Reads are forced to zero for index 0 and for the whole clear window.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rdata[r] = '0;
      if (ready && (raddr[r] != '0)) begin
        rdata[r] = rf_q[raddr[r]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
          if (rf_if.i_wen[k] && (waddr[k] == raddr[r])) rdata[r] = wdata[k];
        end
`endif
      end
    end
  end

  assign rf_if.o_ready     = ready;
  assign rf_if.o_wconflict = wconflict_q;
  assign rf_if.s_a0zero    = ~ready | ~(|rf_q[A0_IDX]);

endmodule
